// File: rtl/serial_char_rx_pkg.sv
// Shared definitions for the serial receive front-end and the toupper stage.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package serial_char_rx_pkg;

  // Receiver frame-tracking states
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } rx_state_t;

  // ASCII letter range and the bit that separates lower from upper case
  localparam logic [7:0] ASCII_LOWER_A  = 8'h61;
  localparam logic [7:0] ASCII_LOWER_Z  = 8'h7A;
  localparam int         ASCII_CASE_BIT = 5;

  // One queued character: the byte plus its precomputed lower-case flag
  typedef struct packed {
    logic       lower;
    logic [7:0] data;
  } char_t;

  localparam int CHAR_W = $bits(char_t);

  function automatic logic is_lower(input logic [7:0] b);
    return (b >= ASCII_LOWER_A) && (b <= ASCII_LOWER_Z);
  endfunction

endpackage

// File: rtl/char_fifo.sv
// Small circular queue with wrap-bit pointers; head entry is shown combinationally from storage flops.
// Latency: a push is visible at the head the cycle after it is written into an empty queue.
// Backpressure: push while full is ignored unless a pop happens in the same cycle.
module char_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head_dat
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // A pop frees the slot the simultaneous push lands in, so full+pop still accepts
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Head reads as zero when nothing is queued so the outputs are clean while invalid
  assign head_dat = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  // Pointer advance on accepted push / pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Entry storage, written at the tail slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_dat;
    end
  end

endmodule

// File: rtl/serial_char_rx.sv
// 8N1 serial line deserialiser feeding a small byte queue with a per-byte lower-case flag.
// Latency: char_valid rises 2 clk after the stop-bit sample when the queue was empty.
// Backpressure: char_ready low holds the head; a byte arriving to a full queue is dropped with an overrun pulse.
module serial_char_rx
  import serial_char_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic [7:0] char_data,
  output logic       char_lower,
  output logic       char_valid,
  input  logic       char_ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int                CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic             rxd_meta;
  logic             rxd_s;
  rx_state_t        state_q;
  rx_state_t        state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_q;
  logic [7:0]       shift_q;
  logic             half_tick;
  logic             bit_tick;
  logic             cnt_clr;
  logic             bit_clr;
  logic             data_smp;
  logic             stop_ok;
  logic             stop_bad;
  logic             push_q;
  char_t            push_dat_q;
  logic             frame_err_q;
  logic             overrun_q;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;
  char_t            head;

  assign half_tick = (cnt_q == HALF_LAST);
  assign bit_tick  = (cnt_q == BIT_LAST);

  // Two-flop synchroniser; resets to the idle line level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
    end else begin
      rxd_meta <= rxd;
      rxd_s    <= rxd_meta;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state: start detect, mid-bit sampling, stop check, break recovery
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (!rxd_s)    state_d = ST_START;
      ST_START:     if (half_tick) state_d = rxd_s ? ST_IDLE : ST_DATA;
      ST_DATA:      if (bit_tick && (bit_q == 3'd7)) state_d = ST_STOP;
      ST_STOP:      if (bit_tick)  state_d = rxd_s ? ST_IDLE : ST_WAIT_IDLE;
      ST_WAIT_IDLE: if (rxd_s)     state_d = ST_IDLE;
      default:                     state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: counter control and sample strobes
  always_comb begin
    cnt_clr  = 1'b0;
    bit_clr  = 1'b0;
    data_smp = 1'b0;
    stop_ok  = 1'b0;
    stop_bad = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_clr = 1'b1;
        bit_clr = 1'b1;
      end
      ST_START: cnt_clr = half_tick;
      ST_DATA: begin
        cnt_clr  = bit_tick;
        data_smp = bit_tick;
      end
      ST_STOP: begin
        cnt_clr  = bit_tick;
        stop_ok  = bit_tick & rxd_s;
        stop_bad = bit_tick & ~rxd_s;
      end
      default: cnt_clr = 1'b1;
    endcase
  end

  // Baud counter: restarts at every sample point and while waiting for a start edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       cnt_q <= '0;
    else if (cnt_clr) cnt_q <= '0;
    else              cnt_q <= cnt_q + 1'b1;
  end

  // Bit counter and LSB-first shift register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_q   <= '0;
      shift_q <= '0;
    end else if (bit_clr) begin
      bit_q   <= '0;
    end else if (data_smp) begin
      shift_q[bit_q] <= rxd_s;
      bit_q          <= bit_q + 1'b1;
    end
  end

  // Push stage: a good stop bit hands the byte and its case flag to the queue next cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      push_q     <= 1'b0;
      push_dat_q <= '0;
    end else begin
      push_q <= stop_ok;
      if (stop_ok) push_dat_q <= '{lower: is_lower(shift_q), data: shift_q};
    end
  end

  // Error pulses; they come from different frame phases so never coincide
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= stop_bad;
      overrun_q   <= push_q & fifo_full & ~pop;
    end
  end

  assign pop = char_valid & char_ready;

  char_fifo #(
    .WIDTH (CHAR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push_q),
    .push_dat (push_dat_q),
    .pop      (pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head_dat (head)
  );

  assign char_valid = ~fifo_empty;
  assign char_data  = head.data;
  assign char_lower = head.lower;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;

endmodule
